// File: rtl/max7219_pkg.sv
// Shared definitions for the MAX7219 serial link: register addresses, receiver
// FSM encoding and default frame length. The driver side imports the same package
// so that both ends agree on the register map.
package max7219_pkg;

    localparam int FRAME_BITS_DEFAULT = 16;

    localparam logic [3:0] ADDR_NOOP      = 4'h0;
    localparam logic [3:0] ADDR_DIGIT0    = 4'h1;
    localparam logic [3:0] ADDR_DIGIT1    = 4'h2;
    localparam logic [3:0] ADDR_DIGIT2    = 4'h3;
    localparam logic [3:0] ADDR_DIGIT3    = 4'h4;
    localparam logic [3:0] ADDR_DIGIT4    = 4'h5;
    localparam logic [3:0] ADDR_DIGIT5    = 4'h6;
    localparam logic [3:0] ADDR_DIGIT6    = 4'h7;
    localparam logic [3:0] ADDR_DIGIT7    = 4'h8;
    localparam logic [3:0] ADDR_DECODE    = 4'h9;
    localparam logic [3:0] ADDR_INTENSITY = 4'hA;
    localparam logic [3:0] ADDR_SCANLIMIT = 4'hB;
    localparam logic [3:0] ADDR_SHUTDOWN  = 4'hC;
    localparam logic [3:0] ADDR_TEST      = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } rx_state_t;

    // True for the eight digit register addresses.
    function automatic logic is_digit_addr(input logic [3:0] addr);
        return (addr >= ADDR_DIGIT0) && (addr <= ADDR_DIGIT7);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Multi-stage flop synchroniser for one asynchronous level signal.
// STAGES sets the depth (>= 2).
module sync_2ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the asynchronous input through the flop chain.
    // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) chain <= '0;
        else        chain <= {chain[STAGES-2:0], d};
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/max7219_rx.sv
// MAX7219 serial receiver: synchronises DIN/CS/SCLK into clk, shifts frames and
// decodes committed frames into the MAX7219 register file.
// Optional feature: define MAX7219_RX_DOUT_EN to drive the daisy-chain output dout
// (DIN delayed by FRAME_BITS clocks, updated on max_clk falls); otherwise dout = 0.
module max7219_rx
    import max7219_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = FRAME_BITS_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        max_din,
    input  logic        max_cs,
    input  logic        max_clk,
    output logic [63:0] digits,
    output logic [7:0]  decode_mode,
    output logic [3:0]  intensity,
    output logic [2:0]  scan_limit,
    output logic        shutdown_n,
    output logic        display_test,
    output logic        frame_valid,
    output logic [3:0]  frame_addr,
    output logic [7:0]  frame_data,
    output logic        frame_err,
    output logic        dout
);

`ifdef MAX7219_RX_DOUT_EN
    localparam int SHREG_W = FRAME_BITS;   // full frame needed for the chain output
`else
    localparam int SHREG_W = 12;           // only address and data are ever decoded
`endif
    localparam logic [4:0] FRAME_CNT = 5'(FRAME_BITS);

    logic [1:0]         rst_pipe;
    logic               rst_sync_n;
    logic               din_s, cs_s, sclk_s;
    logic               cs_prev, sclk_prev;
    logic               cs_fall, cs_rise, sclk_rise;
    rx_state_t          state;
    logic [4:0]         bit_cnt, cnt_next;
    logic [SHREG_W-1:0] shreg, shreg_next;
    logic [3:0]         addr_next;
    logic [7:0]         data_next;
    logic [2:0]         digit_idx;

    // Reset asserts immediately and releases in step with clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_pipe <= '0;
        else        rst_pipe <= {rst_pipe[0], 1'b1};
    end
    assign rst_sync_n = rst_pipe[1];

    sync_2ff #(.STAGES(SYNC_STAGES)) u_sync_din (.clk(clk), .rst_n(rst_sync_n), .d(max_din), .q(din_s));
    sync_2ff #(.STAGES(SYNC_STAGES)) u_sync_cs  (.clk(clk), .rst_n(rst_sync_n), .d(max_cs),  .q(cs_s));
    sync_2ff #(.STAGES(SYNC_STAGES)) u_sync_clk (.clk(clk), .rst_n(rst_sync_n), .d(max_clk), .q(sclk_s));

    // Delayed copies of the synchronised CS and SCLK for edge detection.
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            cs_prev   <= 1'b0;
            sclk_prev <= 1'b0;
        end else begin
            cs_prev   <= cs_s;
            sclk_prev <= sclk_s;
        end
    end

    assign cs_fall   = ~cs_s & cs_prev;
    assign cs_rise   =  cs_s & ~cs_prev;
    assign sclk_rise =  sclk_s & ~sclk_prev;

    // Shift/count lookahead so a bit arriving with the CS rise is part of the frame.
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        shreg_next = shreg;
        cnt_next   = bit_cnt;
        if (sclk_rise) begin
            shreg_next = {shreg[SHREG_W-2:0], din_s};
            cnt_next   = (bit_cnt == 5'd31) ? bit_cnt : bit_cnt + 5'd1;
        end
    end

    assign addr_next = shreg_next[11:8];
    assign data_next = shreg_next[7:0];
    assign digit_idx = addr_next[2:0] - 3'd1;   // addr 1..8 -> 0..7

    // Frame FSM with registered register file, frame strobes and chain output.
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state        <= ST_IDLE;
            bit_cnt      <= '0;
            shreg        <= '0;
            digits       <= '0;
            decode_mode  <= '0;
            intensity    <= '0;
            scan_limit   <= '0;
            shutdown_n   <= 1'b0;
            display_test <= 1'b0;
            frame_valid  <= 1'b0;
            frame_addr   <= '0;
            frame_data   <= '0;
            frame_err    <= 1'b0;
`ifdef MAX7219_RX_DOUT_EN
            dout         <= 1'b0;
`endif
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state   <= ST_SHIFT;
                        bit_cnt <= '0;
                    end
                end
                ST_SHIFT: begin
                    shreg   <= shreg_next;
                    bit_cnt <= cnt_next;
`ifdef MAX7219_RX_DOUT_EN
                    if (~sclk_s & sclk_prev) dout <= shreg[SHREG_W-1];
`endif
                    if (cs_rise) begin
                        if (cnt_next >= FRAME_CNT) begin
                            state       <= ST_COMMIT;
                            frame_valid <= 1'b1;
                            frame_addr  <= addr_next;
                            frame_data  <= data_next;
                            if (is_digit_addr(addr_next))
                                digits[{digit_idx, 3'b000} +: 8] <= data_next;
                            case (addr_next)
                                ADDR_DECODE:    decode_mode  <= data_next;
                                ADDR_INTENSITY: intensity    <= data_next[3:0];
                                ADDR_SCANLIMIT: scan_limit   <= data_next[2:0];
                                ADDR_SHUTDOWN:  shutdown_n   <= data_next[0];
                                ADDR_TEST:      display_test <= data_next[0];
                                default: ;
                            endcase
                        end else begin
                            state     <= ST_IDLE;
                            frame_err <= (cnt_next != 5'd0);
                        end
                    end
                end
                ST_COMMIT: state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

`ifndef MAX7219_RX_DOUT_EN
    assign dout = 1'b0;
`endif

endmodule

// File: tb/tb_max7219_rx.sv
// Directed self-checking bench for max7219_rx: SCLK = clk/8, frames driven MSB first.
// Also build with MAX7219_RX_DOUT_EN defined to exercise the daisy-chain output.
module tb_max7219_rx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        max_din, max_cs, max_clk;
    logic [63:0] digits;
    logic [7:0]  decode_mode;
    logic [3:0]  intensity;
    logic [2:0]  scan_limit;
    logic        shutdown_n, display_test;
    logic        frame_valid, frame_err, dout;
    logic [3:0]  frame_addr;
    logic [7:0]  frame_data;

    int checks = 0;
    int errors = 0;

    max7219_rx dut (
        .clk(clk), .rst_n(rst_n), .max_din(max_din), .max_cs(max_cs), .max_clk(max_clk),
        .digits(digits), .decode_mode(decode_mode), .intensity(intensity), .scan_limit(scan_limit),
        .shutdown_n(shutdown_n), .display_test(display_test), .frame_valid(frame_valid),
        .frame_addr(frame_addr), .frame_data(frame_data), .frame_err(frame_err), .dout(dout)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Shift n bits of value, MSB first; optionally compare dout while SCLK is high.
    task automatic send_bits(input logic [31:0] value, input int n, input bit chk_dout);
        logic exp_dout;
        for (int k = 1; k <= n; k++) begin
            max_din = value[n-k];
            tick(4);
            max_clk = 1'b1;
            tick(2);
            if (chk_dout) begin
`ifdef MAX7219_RX_DOUT_EN
                if (k > 16) begin
                    exp_dout = value[n-(k-16)];
                    checks++;
                    if (dout !== exp_dout) begin
                        errors++;
                        $display("FAIL dout bit %0d: got %b expected %b", k, dout, exp_dout);
                    end
                end
`else
                exp_dout = 1'b0;
                checks++;
                if (dout !== exp_dout) begin
                    errors++;
                    $display("FAIL dout bit %0d: got %b expected %b", k, dout, exp_dout);
                end
`endif
            end
            tick(2);
            max_clk = 1'b0;
        end
    endtask

    // Full CS-framed transfer; counts frame_valid/frame_err pulses after CS rises.
    task automatic send_frame(input logic [31:0] value, input int n, input bit chk_dout,
                              output int nv, output int ne);
        max_cs = 1'b0;
        tick(4);
        send_bits(value, n, chk_dout);
        tick(4);
        max_cs = 1'b1;
        nv = 0;
        ne = 0;
        for (int i = 0; i < 16; i++) begin
            tick(1);
            if (frame_valid === 1'b1) nv++;
            if (frame_err === 1'b1)   ne++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; max_cs = 1'b1; max_clk = 1'b0; max_din = 1'b0;
        tick(3);
        checks++;
        if ({digits, decode_mode, intensity, scan_limit, shutdown_n, display_test,
             frame_valid, frame_addr, frame_data, frame_err, dout} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got nonzero outputs, expected all 0 (shutdown_n=%b)", shutdown_n);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            checks++;
            if (frame_valid !== 1'b0 || frame_err !== 1'b0) begin
                errors++;
                $display("FAIL reset_release_pulse: got valid=%b err=%b expected 0 0", frame_valid, frame_err);
            end
        end
    endtask

    task automatic test_basic_frame;
        int nv, ne;
        send_frame(32'h0A05, 16, 1'b0, nv, ne);
        checks++;
        if (intensity !== 4'h5) begin errors++; $display("FAIL intensity: got %h expected 5", intensity); end
        checks++;
        if (nv !== 1 || ne !== 0) begin errors++; $display("FAIL t1_pulses: got valid=%0d err=%0d expected 1 0", nv, ne); end
        checks++;
        if (frame_addr !== 4'hA || frame_data !== 8'h05) begin
            errors++; $display("FAIL t1_frame: got %h/%h expected a/05", frame_addr, frame_data);
        end
    endtask

    task automatic test_decode;
        int nv, ne;
        send_frame(32'h0309, 16, 1'b0, nv, ne);
        checks++;
        if (digits !== 64'h0000_0000_0009_0000) begin errors++; $display("FAIL digit3: got %h expected 0000000000090000", digits); end
        send_frame(32'h08AB, 16, 1'b0, nv, ne);
        checks++;
        if (digits !== 64'hAB00_0000_0009_0000) begin errors++; $display("FAIL digit8: got %h expected ab00000000090000", digits); end
        send_frame(32'h0D55, 16, 1'b0, nv, ne);
        checks++;
        if (nv !== 1 || frame_addr !== 4'hD || frame_data !== 8'h55) begin
            errors++; $display("FAIL addr_d: got valid=%0d %h/%h expected 1 d/55", nv, frame_addr, frame_data);
        end
        checks++;
        if (digits !== 64'hAB00_0000_0009_0000 || intensity !== 4'h5 || decode_mode !== 8'h00) begin
            errors++; $display("FAIL addr_d_nowrite: got digits=%h int=%h dec=%h", digits, intensity, decode_mode);
        end
        send_frame(32'h0BFF, 16, 1'b0, nv, ne);
        checks++;
        if (scan_limit !== 3'h7) begin errors++; $display("FAIL scan_limit: got %h expected 7", scan_limit); end
        send_frame(32'h09F0, 16, 1'b0, nv, ne);
        checks++;
        if (decode_mode !== 8'hF0) begin errors++; $display("FAIL decode_mode: got %h expected f0", decode_mode); end
        send_frame(32'hFA3C, 16, 1'b0, nv, ne);
        checks++;
        if (intensity !== 4'hC || frame_addr !== 4'hA) begin
            errors++; $display("FAIL upper_nibble: got int=%h addr=%h expected c a", intensity, frame_addr);
        end
    endtask

    task automatic test_short_frame;
        int nv, ne;
        send_frame(32'h0A0F, 15, 1'b0, nv, ne);
        checks++;
        if (nv !== 0 || ne !== 1) begin errors++; $display("FAIL short_pulses: got valid=%0d err=%0d expected 0 1", nv, ne); end
        checks++;
        if (intensity !== 4'hC || frame_addr !== 4'hA || frame_data !== 8'h3C) begin
            errors++; $display("FAIL short_nochange: got int=%h %h/%h expected c a/3c", intensity, frame_addr, frame_data);
        end
        send_frame(32'h0, 0, 1'b0, nv, ne);
        checks++;
        if (nv !== 0 || ne !== 0) begin errors++; $display("FAIL empty_frame: got valid=%0d err=%0d expected 0 0", nv, ne); end
    endtask

    task automatic test_long_frame;
        int nv, ne;
        send_frame(32'h5_0C01, 20, 1'b0, nv, ne);
        checks++;
        if (shutdown_n !== 1'b1) begin errors++; $display("FAIL shutdown_n: got %b expected 1", shutdown_n); end
        checks++;
        if (nv !== 1 || ne !== 0 || frame_addr !== 4'hC || frame_data !== 8'h01) begin
            errors++; $display("FAIL long_frame: got valid=%0d err=%0d %h/%h expected 1 0 c/01", nv, ne, frame_addr, frame_data);
        end
    endtask

    task automatic test_reset_mid_frame;
        int nv, ne;
        max_cs = 1'b0;
        tick(4);
        send_bits(32'h0F, 8, 1'b0);
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(4);
        send_bits(32'h01, 8, 1'b0);
        tick(4);
        max_cs = 1'b1;
        nv = 0; ne = 0;
        for (int i = 0; i < 16; i++) begin
            tick(1);
            if (frame_valid === 1'b1) nv++;
            if (frame_err === 1'b1)   ne++;
        end
        checks++;
        if (nv !== 0 || ne !== 0) begin errors++; $display("FAIL midreset_pulses: got valid=%0d err=%0d expected 0 0", nv, ne); end
        checks++;
        if ({digits, decode_mode, intensity, scan_limit, shutdown_n, display_test, frame_addr, frame_data} !== '0) begin
            errors++; $display("FAIL midreset_regs: got digits=%h int=%h shut=%b test=%b expected all 0",
                               digits, intensity, shutdown_n, display_test);
        end
        send_frame(32'h0F01, 16, 1'b0, nv, ne);
        checks++;
        if (display_test !== 1'b1 || nv !== 1) begin
            errors++; $display("FAIL display_test: got %b valid=%0d expected 1 1", display_test, nv);
        end
    endtask

    task automatic test_back_to_back_dout;
        int nv, ne;
        send_frame(32'h0102_0A07, 32, 1'b1, nv, ne);
        checks++;
        if (intensity !== 4'h7 || frame_addr !== 4'hA || frame_data !== 8'h07 || nv !== 1) begin
            errors++; $display("FAIL chain_frame: got int=%h %h/%h valid=%0d expected 7 a/07 1",
                               intensity, frame_addr, frame_data, nv);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_decode();
        test_short_frame();
        test_long_frame();
        test_reset_mid_frame();
        test_back_to_back_dout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
